// File: rtl/cheri_dmem_pkg.sv
// Shared types for the CHERIoT data-memory bridge: response bookkeeping and tag position.
// No logic; no latency or backpressure of its own.
package cheri_dmem_pkg;

  localparam int          TagBit     = 32;
  localparam logic [31:0] DefMemBase = 32'h2000_0000;

  typedef struct packed {
    logic valid;
    logic err;
    logic is_cap;
    logic we;
  } resp_info_t;

endpackage

// File: rtl/cheri_dmem_resp_pipe.sv
// Fixed-depth shift register of response info; output is Depth cycles behind input.
// Loads every cycle, never stalls; asynchronous clear drops everything in flight.
module cheri_dmem_resp_pipe
  import cheri_dmem_pkg::*;
#(
  parameter int Depth = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  resp_info_t in_i,
  output resp_info_t out_o
);

  resp_info_t stage_q [Depth];
  resp_info_t stage_d [Depth];

  always_comb begin
    stage_d[0] = in_i;
    for (int i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_o = stage_q[Depth-1];

endmodule

// File: rtl/cheri_dmem_bridge.sv
// Core tagged data port to data SRAM + granule tag SRAM; responses MemLatency cycles after grant.
// Grant follows the arbiter (errored requests grant at once); responses cannot be stalled.
module cheri_dmem_bridge
  import cheri_dmem_pkg::*;
#(
  parameter logic [31:0] MemBase    = DefMemBase,
  parameter int          MemWords   = 16384,
  parameter int          MemLatency = 1,
  parameter int          AddrW      = $clog2(MemWords)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             data_req_i,
  input  logic             data_is_cap_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [32:0]      data_wdata_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  output logic [32:0]      data_rdata_o,
  output logic             data_err_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  output logic             tag_req_o,
  output logic             tag_we_o,
  output logic [AddrW-2:0] tag_addr_o,
  output logic             tag_wdata_o,
  input  logic             tag_rdata_i
);

  localparam logic [32:0] WindowBytes = 33'(MemWords) << 2;

  logic [31:0]      offset;
  logic [AddrW-1:0] word;
  logic             in_range;
  logic             err_req;
  logic             granted;
  resp_info_t       resp_in;
  resp_info_t       resp_out;

  // Wrap-around subtraction makes addresses below MemBase land out of range too.
  assign offset   = data_addr_i - MemBase;
  assign in_range = {1'b0, offset} < WindowBytes;
  assign word     = AddrW'(offset >> 2);

  assign err_req = ~in_range
                 | (data_is_cap_i & (data_be_i != 4'hF))
                 | (data_is_cap_i & (data_addr_i[1:0] != 2'b00));

  assign mem_req_o   = data_req_i & ~err_req;
  assign granted     = mem_req_o & mem_gnt_i;
  assign data_gnt_o  = data_req_i & (err_req | mem_gnt_i);
  assign mem_we_o    = data_we_i;
  assign mem_be_o    = data_be_i;
  assign mem_addr_o  = word;
  assign mem_wdata_o = data_wdata_i[31:0];

  // Any plain store into a granule invalidates its capability.
  assign tag_req_o   = granted & (data_is_cap_i | data_we_i);
  assign tag_we_o    = tag_req_o & data_we_i & (data_is_cap_i | (|data_be_i));
  assign tag_wdata_o = data_is_cap_i & data_wdata_i[TagBit];
  assign tag_addr_o  = word[AddrW-1:1];

  always_comb begin
    resp_in = '0;
    if (data_gnt_o) begin
      resp_in.valid  = 1'b1;
      resp_in.err    = err_req;
      resp_in.is_cap = data_is_cap_i;
      resp_in.we     = data_we_i;
    end
  end

  cheri_dmem_resp_pipe #(
    .Depth (MemLatency)
  ) u_resp_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .in_i  (resp_in),
    .out_o (resp_out)
  );

  assign data_rvalid_o = resp_out.valid;
  assign data_err_o    = resp_out.err;

  always_comb begin
    data_rdata_o = '0;
    if (resp_out.valid && !resp_out.err) begin
      data_rdata_o[TagBit] = resp_out.is_cap & ~resp_out.we & tag_rdata_i;
      data_rdata_o[31:0]   = resp_out.we ? 32'h0 : mem_rdata_i;
    end
  end

endmodule
